// File: rtl/rnd_pkg.sv
// Shared types and helpers for the randomness reseed buffer.
package rnd_pkg;

   localparam int SEED_W = 80;

   typedef enum logic [2:0] {
      S_SEED,
      S_START,
      S_WAIT_HI,
      S_WAIT_LO,
      S_RUN
   } state_t;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int clog2(input int unsigned v);
      int r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/rnd_fifo.sv
// First-word-fall-through FIFO; head always shows the oldest stored word.
module rnd_fifo
   import rnd_pkg::*;
#(
   parameter int W     = 512,
   parameter int DEPTH = 4,
   localparam int AW   = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   input  logic          flush,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic [W-1:0]  head
);

   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // A full FIFO refuses pushes even when a pop frees a slot this cycle.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/rnd_reseed_buffer.sv
// Buffers PRNG words for a masked AES core and sequences PRNG (re)seeding.
module rnd_reseed_buffer
   import rnd_pkg::*;
#(
   parameter int RND_W         = 512,
   parameter int DEPTH         = 4,
   parameter int RESEED_PERIOD = 1024,
   parameter int CNT_W         = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SEED_W-1:0] seed_in,
   input  logic              seed_valid,
   output logic              seed_ready,
   input  logic              reseed_req,
   output logic [SEED_W-1:0] prng_seed,
   output logic              prng_start_reseed,
   input  logic              prng_busy,
   input  logic              prng_out_valid,
   output logic              prng_out_ready,
   input  logic [RND_W-1:0]  prng_rnd,
   output logic [RND_W-1:0]  rnd_out,
   output logic              rnd_valid,
   input  logic              rnd_ready,
   output logic [CNT_W-1:0]  words_served,
   output logic              reseed_pending
);

   localparam int AW        = clog2(DEPTH);
   localparam int PW_RAW    = clog2(RESEED_PERIOD + 1);
   localparam int PW        = (PW_RAW < 1) ? 1 : PW_RAW;
   localparam bit PERIOD_EN = (RESEED_PERIOD != 0);
   localparam logic [PW-1:0] PERIOD_MAX = PW'(RESEED_PERIOD);

   state_t           state;
   state_t           state_nxt;
   logic [PW-1:0]    period_cnt;
   logic [AW:0]      fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic [RND_W-1:0] fifo_head;
   logic             running;
   logic             push;
   logic             pop;
   logic             period_hit;
   logic             trigger;

   assign running           = (state == S_RUN);
   assign seed_ready        = (state == S_SEED);
   assign prng_start_reseed = (state == S_START);
   assign reseed_pending    = ~running;

   assign prng_out_ready = running & ~fifo_full;
   assign rnd_valid      = running & (fifo_count != '0);
   assign rnd_out        = (running & ~fifo_empty) ? fifo_head : '0;
   assign push           = prng_out_valid & prng_out_ready;
   assign pop            = rnd_valid & rnd_ready;

   // The pop of the trigger cycle counts, so the last allowed word still goes out.
   assign period_hit = PERIOD_EN && ((period_cnt + PW'(pop)) == PERIOD_MAX);
   assign trigger    = running & (reseed_req | period_hit);

   rnd_fifo #(
      .W     (RND_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (prng_rnd),
      .pop   (pop),
      .flush (trigger),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count),
      .head  (fifo_head)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_SEED;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_SEED:    if (seed_valid) state_nxt = S_START;
         S_START:   state_nxt = S_WAIT_HI;
         S_WAIT_HI: if (prng_busy) state_nxt = S_WAIT_LO;
         S_WAIT_LO: if (!prng_busy) state_nxt = S_RUN;
         S_RUN:     if (trigger) state_nxt = S_SEED;
         default:   state_nxt = S_SEED;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_cnt   <= '0;
         words_served <= '0;
         prng_seed    <= '0;
      end else begin
         if (trigger)                period_cnt <= '0;
         else if (pop && PERIOD_EN)  period_cnt <= period_cnt + PW'(1);
         if (pop && (words_served != '1)) words_served <= words_served + CNT_W'(1);
         if (seed_ready && seed_valid)    prng_seed <= seed_in;
      end
   end

endmodule

// File: doc/rnd_reseed_buffer.md
Name: rnd_reseed_buffer

Overview:
- Parametrised randomness front-end between `prng_top` and a masked AES core.
- Buffers PRNG output words in a DEPTH-entry first-word-fall-through FIFO and serves whole words to the core over valid/ready.
- Sequences seeding and reseeding of the PRNG, both periodic (every RESEED_PERIOD served words) and on demand. A flush on every reseed guarantees no pre-reseed word is ever delivered.

Parameters:
- RND_W, 512: width of one randomness word (PRNG out_rnd width).
- DEPTH, 4: FIFO entries, power of two, at least 2.
- RESEED_PERIOD, 1024: words served between automatic reseeds; 0 disables automatic reseed.
- CNT_W, 32: width of the served-word counter.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous reset, active-high.
- seed_in, in, 80: new seed from the external seed source.
- seed_valid, in, 1: seed_in is valid.
- seed_ready, out, 1: block accepts a seed.
- reseed_req, in, 1: single-cycle request for an on-demand reseed.
- prng_seed, out, 80: latched seed, to PRNG seed.
- prng_start_reseed, out, 1: one-cycle pulse, to PRNG start_reseed.
- prng_busy, in, 1: PRNG busy.
- prng_out_valid, in, 1: PRNG word valid.
- prng_out_ready, out, 1: FIFO accepts a PRNG word.
- prng_rnd, in, RND_W: PRNG word.
- rnd_out, out, RND_W: randomness to the core; forced to 0 whenever rnd_valid=0.
- rnd_valid, out, 1: rnd_out holds a fresh, never-served word.
- rnd_ready, in, 1: core consumes rnd_out this cycle.
- words_served, out, CNT_W: total words delivered since reset; saturates at all-ones.
- reseed_pending, out, 1: high in every state except S_RUN.

Behaviour:
- Reset, asynchronous: state S_SEED, FIFO empty, period counter 0, prng_seed 0, words_served 0.
  - Outputs in reset: prng_start_reseed 0, prng_out_ready 0, rnd_valid 0, rnd_out 0, reseed_pending 1, seed_ready 1.
  - Seed handshakes are ignored while rst=1.
- Reset asserted mid-operation aborts any state immediately. FIFO contents are discarded, and the first PRNG word after release is accepted only after a full S_SEED..S_WAIT_LO sequence.
- FSM:
  - S_SEED: seed_ready=1. When seed_valid & seed_ready, latch prng_seed <= seed_in and go to S_START.
  - S_START: prng_start_reseed=1 for exactly this one cycle, then go to S_WAIT_HI.
  - S_WAIT_HI: wait for prng_busy=1, then go to S_WAIT_LO.
  - S_WAIT_LO: wait for prng_busy=0, then go to S_RUN.
  - S_RUN: normal service. Exit to S_SEED on the cycle after a reseed trigger.
- Reseed trigger, evaluated in S_RUN only:
  - reseed_req=1; or
  - RESEED_PERIOD != 0 and the period counter reaches RESEED_PERIOD after this cycle's pop.
  - reseed_req outside S_RUN is ignored; a reseed is already pending.
- A pop handshake in the trigger cycle completes normally. The counter then reaches RESEED_PERIOD exactly on the last allowed word, and no further word is served.
- Flush: on entry to S_SEED the FIFO is emptied and the period counter cleared; words_served is not cleared.
- Outside S_RUN: prng_out_ready=0 and rnd_valid=0.
- FIFO push: prng_out_ready = (state==S_RUN) & (count<DEPTH). A word is pushed on prng_out_valid & prng_out_ready.
  - When full, no push is accepted even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full keeps count unchanged.
- FIFO pop: rnd_valid = (state==S_RUN) & (count>0); rnd_out = head. A word is popped on rnd_valid & rnd_ready.
  - A popped word is never presented again.
  - A word pushed in cycle t is visible at rnd_out in cycle t+1; this is the minimum latency.
  - The rnd_ready=1 / rnd_valid=0 combination is harmless.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- words_served increments by 1 on each pop and saturates. The period counter is log2(RESEED_PERIOD+1) bits, minimum 1.

Decomposition:
- Package rnd_pkg:
  - FSM state enum (S_SEED, S_START, S_WAIT_HI, S_WAIT_LO, S_RUN);
  - SEED_W=80;
  - clog2 helper.
- Sub-module rnd_fifo: FWFT FIFO with parameters W and DEPTH and ports push, pop, flush, full, empty, count, head.
- The FSM, counters and output gating live in the top.

Test Plan:
- Basic: reset, then seed 80'h1234 accepted. Then:
  - prng_start_reseed high for exactly 1 cycle;
  - busy high 3 cycles then low, state reaches S_RUN;
  - PRNG words 1,2,3 with rnd_ready=1 appear in order, each 1 cycle after push;
  - words_served=3.
- Backpressure: DEPTH=4, rnd_ready=0, PRNG offers 6 words. Then:
  - prng_out_ready drops after 4 pushes;
  - releasing rnd_ready yields 1..4 and then 5, 6;
  - no word is duplicated or dropped.
- Periodic reseed: RESEED_PERIOD=3, PRNG feeds words 10..15. Then:
  - 10, 11, 12 are served, after which rnd_valid=0 and reseed_pending=1;
  - after the new seed and busy cycle, the first served word is a freshly pushed word, never 13.
- On-demand reseed: reseed_req and a pop of word 7 in the same cycle. Word 7 is delivered, the FIFO is flushed and the state returns to S_SEED. RESEED_PERIOD=0 causes no automatic reseed across 5000 words.
- Reset mid-run: rst asserted with 3 words buffered. Then:
  - rnd_valid=0, rnd_out=0, words_served=0 and seed_ready=1 immediately;
  - no buffered word reappears after re-seeding.
- Saturation: CNT_W=4, 20 pops leave words_served=15.
